// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial instruction memory loader
//
// Purpose: accepts 32-bit instruction words over a valid/ready handshake and
// writes them big-endian, one byte per cycle, into a byte-wide instruction
// memory starting at a latched base address. Writes past MEM_BYTES-1 abort
// the load and raise a sticky error flag.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   start              load request (IDLE only), latches base_addr/word_count
//   base_addr          first byte address of the load
//   word_count         number of words to load (0 allowed)
//   word_in/valid      incoming instruction word and its valid flag
//   word_ready         loader accepts word_in this cycle
//   mem_addr/data/we   byte write port to the instruction memory
//   busy               high whenever not IDLE
//   done               one-cycle pulse at the end of every load
//   error              sticky out-of-range write flag, cleared on start

module imem_loader #(
  parameter int MEM_BYTES = 51,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        word_count,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_WORD = 2'd1;
  localparam logic [1:0] ST_WRITE     = 2'd2;
  localparam logic [1:0] ST_FIN       = 2'd3;

  // One extra bit so a MEM_BYTES of 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [7:0]        data_hold_q, data_hold_d;

  logic [7:0] cur_byte;
  logic       in_bounds;
  logic       write_ok;

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      2'd0:    cur_byte = word_q[31:24];
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
  end

  assign in_bounds = ({1'b0, ptr_q} < MEM_LIMIT);
  assign write_ok  = (state_q == ST_WRITE) && in_bounds;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    err_d       = err_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = base_addr;
          cnt_d   = word_count;
          err_d   = 1'b0;
          state_d = (word_count == 4'd0) ? ST_FIN : ST_WAIT_WORD;
        end
      end
      ST_WAIT_WORD: begin
        if (word_valid) begin
          word_d  = word_in;
          idx_d   = 2'd0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!in_bounds) begin
          // Abort: the rest of this word and any remaining words are dropped.
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          addr_hold_d = ptr_q;
          data_hold_d = cur_byte;
          ptr_d       = ptr_q + ADDR_W'(1);
          idx_d       = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ST_FIN : ST_WAIT_WORD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      err_q       <= err_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

  // Outputs decode registered state only; the address/data port shows the
  // live byte while strobing and the last written byte otherwise.
  assign word_ready = (state_q == ST_WAIT_WORD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign error      = err_q;
  assign mem_we     = write_ok;
  assign mem_addr   = write_ok ? ptr_q : addr_hold_q;
  assign mem_data   = write_ok ? cur_byte : data_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader

module tb_imem_loader;

  localparam int MEM_BYTES = 51;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        word_count;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .done(done), .error(error)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  int exp_ptr = 0;
  int d0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected (addr, byte).
  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (mem_we === 1'b1) begin
      chk("we_only_in_write", 32'({busy, word_ready, done}), 32'b100);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", 32'({mem_addr, mem_data}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int base, input int cnt);
    start      = 1'b1;
    base_addr  = ADDR_W'(base);
    word_count = 4'(cnt);
    tick();
    start   = 1'b0;
    exp_ptr = base;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int k;
    int waited;
    k = 0;
    while (k < 4 && exp_ptr + k < MEM_BYTES) begin
      exp_q.push_back({ADDR_W'(exp_ptr + k), w[31-8*k -: 8]});
      k++;
    end
    for (int g = 0; g < gap; g++) begin
      chk("stall_ready", 32'(word_ready), 32'd1);
      tick();
    end
    word_in    = w;
    word_valid = 1'b1;
    waited     = 0;
    while (word_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("accept_timeout", 32'(waited < 20), 32'd1);
    tick();
    word_valid = 1'b0;
    word_in    = $urandom();
    for (int i = 0; i < k; i++) begin
      chk("strobe_run", 32'(mem_we), 32'd1);
      tick();
    end
    chk("strobe_end", 32'(mem_we), 32'd0);
    if (k < 4) begin
      tick();
      chk("abort_error", 32'(error), 32'd1);
      chk("abort_done", 32'(done), 32'd1);
    end
    exp_ptr += 4;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("done_timeout", 32'(w < 40), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    word_in = '0; word_valid = 1'b0;
    #3;
    chk("rst_outputs", 32'({word_ready, mem_we, busy, done, error}), 32'd0);
    chk("rst_addr_data", 32'({mem_addr, mem_data}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single word
    d0 = n_done;
    start_load(0, 1);
    chk("single_busy", 32'(busy), 32'd1);
    send_word(32'h8C220004, 0);
    wait_done();
    chk("single_done_cnt", 32'(n_done - d0), 32'd1);
    chk("single_hold", 32'({mem_addr, mem_data}), 32'({6'd3, 8'h04}));
    chk("single_error", 32'(error), 32'd0);

    // Three words with backpressure gaps
    d0 = n_done;
    start_load(8, 3);
    send_word(32'h11223344, 0);
    send_word(32'hA5B6C7D8, 3);
    send_word(32'hDEADBEEF, 1);
    wait_done();
    chk("multi_done_cnt", 32'(n_done - d0), 32'd1);
    chk("multi_drained", 32'(exp_q.size()), 32'd0);

    // Zero count
    d0 = n_done;
    start_load(5, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_ready", 32'(word_ready), 32'd0);
    wait_done();
    chk("zero_done_cnt", 32'(n_done - d0), 32'd1);

    // Overflow past MEM_BYTES
    d0 = n_done;
    start_load(48, 1);
    send_word(32'hC0FFEE77, 0);
    wait_done();
    chk("ovf_done_cnt", 32'(n_done - d0), 32'd1);
    chk("ovf_error_sticky", 32'(error), 32'd1);

    // Async reset mid-word, idx=2 presenting
    start_load(0, 1);
    chk("restart_clears_error", 32'(error), 32'd0);
    exp_q.push_back({6'd0, 8'hCA});
    exp_q.push_back({6'd1, 8'hFE});
    word_in = 32'hCAFEF00D; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_idx2", 32'({mem_we, mem_addr, mem_data}), 32'({1'b1, 6'd2, 8'hF0}));
    #1 reset = 1'b1;
    #1;
    chk("async_rst_we_busy", 32'({mem_we, busy, word_ready, done}), 32'd0);
    chk("async_rst_addr", 32'({mem_addr, mem_data}), 32'd0);
    chk("async_rst_drained", 32'(exp_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    d0 = n_done;
    start_load(0, 1);
    chk("post_rst_start", 32'(busy), 32'd1);
    send_word(32'h01020304, 0);
    wait_done();
    chk("post_rst_done_cnt", 32'(n_done - d0), 32'd1);

    // Start pulses mid-load are ignored
    d0 = n_done;
    start_load(20, 2);
    start = 1'b1; base_addr = 6'd30; word_count = 4'd5;
    tick();
    start = 1'b0;
    chk("ign_start_ready", 32'(word_ready), 32'd1);
    send_word(32'h76543210, 0);
    start = 1'b1; base_addr = 6'd30; word_count = 4'd5;
    tick();
    start = 1'b0;
    send_word(32'h89ABCDEF, 0);
    wait_done();
    chk("ign_done_cnt", 32'(n_done - d0), 32'd1);
    chk("ign_hold", 32'({mem_addr, mem_data}), 32'({6'd27, 8'hEF}));
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 51: number of valid byte locations (0..MEM_BYTES-1) in the target instruction memory.
REQ-002 Parameter ADDR_W, default 6: byte-address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first byte address of the load, latched with start.
REQ-007 word_count  input  4  number of 32-bit words to load, latched with start; 0 is legal.
REQ-008 word_in  input  32  instruction word to store.
REQ-009 word_valid  input  1  word_in holds a valid word.
REQ-010 word_ready  output  1  loader accepts word_in this cycle.
REQ-011 mem_addr  output  ADDR_W  byte write address to the instruction memory.
REQ-012 mem_data  output  8  byte write data.
REQ-013 mem_we  output  1  byte write strobe; the memory writes on the posedge where mem_we=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of every load, normal or aborted.
REQ-016 error  output  1  sticky flag: a write was attempted at an address >= MEM_BYTES.

Function
REQ-017 States SHALL be IDLE, WAIT_WORD, WRITE, and FIN; all outputs SHALL be registered or decoded from registered state only, with no input-to-output combinational path.
REQ-018 IDLE and start=1: latch base_addr into ptr and word_count into cnt, clear error; go to FIN if word_count=0, else go to WAIT_WORD.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 WAIT_WORD: word_ready=1; a word transfers on a posedge with word_valid=1 and word_ready=1, word_in is latched, byte index idx is cleared to 0, and the state moves to WRITE.
REQ-021 word_ready SHALL be 0 in all states except WAIT_WORD.
REQ-022 Byte order is big-endian: idx0 = word[31:24], idx1 = [23:16], idx2 = [15:8], idx3 = [7:0].
REQ-023 WRITE behaviour per cycle:
- mem_we=1, mem_addr=ptr, mem_data=byte(idx);
- at the posedge: ptr+1 (mod 2^ADDR_W) and idx+1.
REQ-024 After idx3 is written: cnt decrements; go to FIN if cnt reaches 0, else go to WAIT_WORD.
REQ-025 Timing for a word accepted at posedge N: bytes are presented in the cycles after edges N, N+1, N+2 and N+3, and the next acceptance is no earlier than edge N+5. Throughput is 1 word per 5 cycles.
REQ-026 Bounds:
- if ptr >= MEM_BYTES in WRITE, mem_we SHALL be 0 for that cycle, error SHALL be set, and the state moves to FIN (abort);
- the remaining bytes and words are discarded.
REQ-027 ptr wrap from 2^ADDR_W-1 to 0 is legal arithmetic; with the default parameters it is unreachable without first triggering REQ-026.
REQ-028 FIN: done=1 for exactly one cycle, then IDLE; busy=1 in FIN.
REQ-029 mem_we SHALL never be 1 outside WRITE; mem_addr and mem_data hold their last values when mem_we=0.
REQ-030 word_valid falling while in WAIT_WORD SHALL stall the loader indefinitely with no timeout.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, mem_we=0, word_ready=0, busy=0, done=0, error=0, mem_addr=0, mem_data=0, ptr=0, cnt=0, and idx=0.
REQ-032 Reset during WRITE SHALL abort mid-word; bytes already written remain in memory, and no further strobes occur.
REQ-033 After reset is released, the first start is honoured on the first posedge it is sampled.

Verification
REQ-034 Single word: start, base=0, count=1, word_in=0x8C220004 -> writes (0,0x8C), (1,0x22), (2,0x00), (3,0x04) on 4 consecutive cycles, then done pulse, busy low.
REQ-035 Multiple words with backpressure: count=3, base=8, word_valid gaps of 0 to 3 cycles -> 12 bytes written to addresses 8..19 in big-endian order, no strobe while waiting, one done.
REQ-036 Zero count: start with word_count=0 -> word_ready never asserted, no mem_we, done one cycle after start.
REQ-037 Overflow: base=48, count=1, MEM_BYTES=51 -> writes to 48, 49, 50, then no strobe at 51, error=1, done pulse; error clears on the next start.
REQ-038 Async reset: assert reset between posedges while idx=2 -> mem_we and busy fall before the next clk edge; the following start with base=0 loads correctly.
REQ-039 Ignored start: pulse start with base=30 mid-load -> no effect on ptr or cnt; the original load completes unchanged.
